// File: rtl/noc_output_arbiter_pkg.sv
// Shared NoC message encodings, arbiter state type and the log2 helper used across
// the cache-hierarchy NoC modules.
package noc_output_arbiter_pkg;

    localparam logic [3:0] MSG_NO_REQ    = 4'd0;
    localparam logic [3:0] MSG_READ      = 4'd1;
    localparam logic [3:0] MSG_RFO       = 4'd2;
    localparam logic [3:0] MSG_WB        = 4'd3;
    localparam logic [3:0] MSG_INV_ACK   = 4'd4;
    localparam logic [3:0] MSG_DATA_RESP = 4'd5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } arb_state_t;

    // Ceiling log2; returns 0 for a value of 1.
    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/noc_output_arbiter_rr_priority_picker.sv
// Round-robin priority picker: first pending port at or after rr_ptr, wrapping modulo
// NUM_PORTS. Purely combinational.
module rr_priority_picker #(
    parameter int NUM_PORTS = 2,
    parameter int PTR_W     = 1
) (
    input  logic [NUM_PORTS-1:0] pending,
    input  logic [PTR_W-1:0]     rr_ptr,
    output logic [PTR_W-1:0]     winner,
    output logic                 any_valid
);

    always_comb begin
        int idx;
        idx       = 0;
        winner    = '0;
        any_valid = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_PORTS;
            if (!any_valid && pending[idx]) begin
                any_valid = 1'b1;
                winner    = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/noc_output_arbiter.sv
// Round-robin arbiter sharing one NoC packetizer among NUM_PORTS hierarchy interfaces;
// registers the granted message and holds it until the packetizer takes it.
module noc_output_arbiter
    import noc_output_arbiter_pkg::*;
#(
    parameter int  NUM_PORTS    = 2,
    parameter int  MSG_BITS     = 4,
    parameter int  ADDRESS_BITS = 32,
    parameter int  DATA_WIDTH   = 32,
    parameter int  OFFSET_BITS  = 2,
    parameter int  ID_BITS      = 2,
    localparam int LINE_WIDTH   = (1 << OFFSET_BITS) * DATA_WIDTH,
    localparam int GRANT_W      = (log2(NUM_PORTS) > 1) ? log2(NUM_PORTS) : 1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_PORTS*MSG_BITS-1:0]     req_msg,
    input  logic [NUM_PORTS*ADDRESS_BITS-1:0] req_address,
    input  logic [NUM_PORTS*LINE_WIDTH-1:0]   req_data,
    input  logic [NUM_PORTS*ID_BITS-1:0]      req_dest_id,
    output logic [NUM_PORTS-1:0]              port_busy,
    input  logic                             packetizer_busy,
    output logic [MSG_BITS-1:0]               noc_msg_out,
    output logic [ADDRESS_BITS-1:0]           noc_address_out,
    output logic [LINE_WIDTH-1:0]             noc_data_out,
    output logic [ID_BITS-1:0]                noc_dest_id,
    output logic [GRANT_W-1:0]                grant_id
);

    localparam logic [MSG_BITS-1:0] NO_REQ = MSG_BITS'(MSG_NO_REQ);

    arb_state_t               state;
    logic [GRANT_W-1:0]       rr_ptr;
    logic [GRANT_W-1:0]       winner;
    logic [GRANT_W-1:0]       next_ptr;
    logic [NUM_PORTS-1:0]     pending;
    logic                     any_valid;
    logic                     reg_free;
    logic                     accept;
    logic [MSG_BITS-1:0]      win_msg;
    logic [ADDRESS_BITS-1:0]  win_address;
    logic [LINE_WIDTH-1:0]    win_data;
    logic [ID_BITS-1:0]       win_dest_id;

    always_comb begin
        pending = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            pending[i] = (req_msg[i*MSG_BITS +: MSG_BITS] != NO_REQ);
        end
    end

    rr_priority_picker #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_W     (GRANT_W)
    ) u_picker (
        .pending   (pending),
        .rr_ptr    (rr_ptr),
        .winner    (winner),
        .any_valid (any_valid)
    );

    // The output register can take a new message when empty, or when the packetizer
    // consumes the held one this cycle (back-to-back, one message per cycle).
    assign reg_free = (state == ST_IDLE) || !packetizer_busy;
    assign accept   = reg_free && any_valid;

    always_comb begin
        win_msg     = req_msg[int'(winner)*MSG_BITS +: MSG_BITS];
        win_address = req_address[int'(winner)*ADDRESS_BITS +: ADDRESS_BITS];
        win_data    = req_data[int'(winner)*LINE_WIDTH +: LINE_WIDTH];
        win_dest_id = req_dest_id[int'(winner)*ID_BITS +: ID_BITS];
        next_ptr    = (winner == GRANT_W'(NUM_PORTS - 1)) ? '0 : winner + GRANT_W'(1);
        port_busy   = '1;
        if (accept) begin
            port_busy[winner] = 1'b0;
        end
    end

    // A message held at reset is dropped; its requester already saw port_busy low.
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= ST_IDLE;
            rr_ptr          <= '0;
            noc_msg_out     <= NO_REQ;
            noc_address_out <= '0;
            noc_data_out    <= '0;
            noc_dest_id     <= '0;
            grant_id        <= '0;
        end else if (reg_free) begin
            if (any_valid) begin
                state           <= ST_SEND;
                noc_msg_out     <= win_msg;
                noc_address_out <= win_address;
                noc_data_out    <= win_data;
                noc_dest_id     <= win_dest_id;
                grant_id        <= winner;
                rr_ptr          <= next_ptr;
            end else begin
                state       <= ST_IDLE;
                noc_msg_out <= NO_REQ;
            end
        end
    end

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Bench for noc_output_arbiter with four ports: directed scenarios plus randomized
// traffic against a behavioural round-robin reference model.
module tb_noc_output_arbiter;
    import noc_output_arbiter_pkg::*;

    localparam int NP = 4;
    localparam int MB = 4;
    localparam int AB = 32;
    localparam int DW = 32;
    localparam int OB = 2;
    localparam int IB = 2;
    localparam int LW = (1 << OB) * DW;
    localparam int GW = 2;
    localparam logic [MB-1:0] NOREQ = MSG_NO_REQ;

    logic              clock;
    logic              reset;
    logic              packetizer_busy;
    logic [NP*MB-1:0]  req_msg;
    logic [NP*AB-1:0]  req_address;
    logic [NP*LW-1:0]  req_data;
    logic [NP*IB-1:0]  req_dest_id;
    logic [NP-1:0]     port_busy;
    logic [MB-1:0]     noc_msg_out;
    logic [AB-1:0]     noc_address_out;
    logic [LW-1:0]     noc_data_out;
    logic [IB-1:0]     noc_dest_id;
    logic [GW-1:0]     grant_id;

    logic [MB-1:0] msg_in  [NP];
    logic [AB-1:0] addr_in [NP];
    logic [LW-1:0] data_in [NP];
    logic [IB-1:0] dest_in [NP];

    // Reference model: the register contents as the specification describes them.
    int            m_ptr;
    bit            m_send;
    logic [MB-1:0] m_msg;
    logic [AB-1:0] m_addr;
    logic [LW-1:0] m_data;
    logic [IB-1:0] m_dest;
    int            m_grant;
    bit            m_free;
    int            m_win;
    logic [NP-1:0] exp_busy;

    int n_checks;
    int n_errors;

    noc_output_arbiter #(
        .NUM_PORTS    (NP),
        .MSG_BITS     (MB),
        .ADDRESS_BITS (AB),
        .DATA_WIDTH   (DW),
        .OFFSET_BITS  (OB),
        .ID_BITS      (IB)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .req_msg         (req_msg),
        .req_address     (req_address),
        .req_data        (req_data),
        .req_dest_id     (req_dest_id),
        .port_busy       (port_busy),
        .packetizer_busy (packetizer_busy),
        .noc_msg_out     (noc_msg_out),
        .noc_address_out (noc_address_out),
        .noc_data_out    (noc_data_out),
        .noc_dest_id     (noc_dest_id),
        .grant_id        (grant_id)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always_comb begin
        req_msg     = '0;
        req_address = '0;
        req_data    = '0;
        req_dest_id = '0;
        for (int i = 0; i < NP; i++) begin
            req_msg[i*MB +: MB]     = msg_in[i];
            req_address[i*AB +: AB] = addr_in[i];
            req_data[i*LW +: LW]    = data_in[i];
            req_dest_id[i*IB +: IB] = dest_in[i];
        end
    end

    task automatic clear_inputs();
        for (int i = 0; i < NP; i++) begin
            msg_in[i]  = NOREQ;
            addr_in[i] = '0;
            data_in[i] = '0;
            dest_in[i] = '0;
        end
    endtask

    task automatic set_port(input int i, input logic [MB-1:0] msg, input logic [AB-1:0] addr,
                            input logic [IB-1:0] dest);
        msg_in[i]  = msg;
        addr_in[i] = addr;
        dest_in[i] = dest;
        data_in[i] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic rand_port(input int i);
        set_port(i, MB'($urandom_range(1, 15)), $urandom, IB'($urandom));
    endtask

    // Decide this cycle's winner from the current inputs and model state.
    task automatic model_eval();
        int idx;
        m_free = !m_send || !packetizer_busy;
        m_win  = -1;
        if (m_free) begin
            for (int k = 0; k < NP; k++) begin
                idx = (m_ptr + k) % NP;
                if (m_win < 0 && msg_in[idx] != NOREQ) m_win = idx;
            end
        end
        exp_busy = '1;
        if (m_win >= 0) exp_busy[m_win] = 1'b0;
    endtask

    task automatic model_commit();
        if (reset) begin
            m_send = 1'b0; m_ptr = 0; m_msg = NOREQ; m_addr = '0; m_data = '0;
            m_dest = '0; m_grant = 0;
        end else if (m_free) begin
            if (m_win >= 0) begin
                m_msg   = msg_in[m_win];
                m_addr  = addr_in[m_win];
                m_data  = data_in[m_win];
                m_dest  = dest_in[m_win];
                m_grant = m_win;
                m_ptr   = (m_win + 1) % NP;
                m_send  = 1'b1;
            end else begin
                m_msg  = NOREQ;
                m_send = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_commit();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        packetizer_busy = 1'b0;
        clear_inputs();
        #1;
        model_eval();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (noc_msg_out !== NOREQ) begin
            n_errors++; $display("FAIL reset_msg got=%h exp=%h", noc_msg_out, NOREQ);
        end
        n_checks++;
        if (noc_address_out !== '0 || noc_data_out !== '0) begin
            n_errors++; $display("FAIL reset_addr_data got addr=%h data=%h exp=0", noc_address_out, noc_data_out);
        end
        n_checks++;
        if (noc_dest_id !== '0 || grant_id !== '0) begin
            n_errors++; $display("FAIL reset_dest_grant got dest=%0d grant=%0d exp=0", noc_dest_id, grant_id);
        end
        #1;
        model_eval();
        n_checks++;
        if (port_busy !== 4'b1111) begin
            n_errors++; $display("FAIL reset_busy got=%b exp=1111", port_busy);
        end
    endtask

    task automatic test_single_req();
        packetizer_busy = 1'b0;
        set_port(1, MSG_RFO, 32'h1000, 2'd2);
        #1;
        model_eval();
        n_checks++;
        if (port_busy !== 4'b1101) begin
            n_errors++; $display("FAIL single_busy got=%b exp=1101", port_busy);
        end
        tick();
        n_checks++;
        if (noc_msg_out !== MSG_RFO || noc_address_out !== 32'h1000 || noc_dest_id !== 2'd2
            || grant_id !== 2'd1) begin
            n_errors++;
            $display("FAIL single_out got msg=%h addr=%h dest=%0d grant=%0d exp msg=%h addr=00001000 dest=2 grant=1",
                     noc_msg_out, noc_address_out, noc_dest_id, grant_id, MSG_RFO);
        end
        n_checks++;
        if (noc_data_out !== data_in[1]) begin
            n_errors++; $display("FAIL single_data got=%h exp=%h", noc_data_out, data_in[1]);
        end
        msg_in[1] = NOREQ;
        #1;
        model_eval();
        n_checks++;
        if (port_busy !== 4'b1111) begin
            n_errors++; $display("FAIL single_busy_after got=%b exp=1111", port_busy);
        end
        tick();
        n_checks++;
        if (noc_msg_out !== NOREQ) begin
            n_errors++; $display("FAIL single_noreq got=%h exp=%h", noc_msg_out, NOREQ);
        end
    endtask

    task automatic test_contention();
        logic [NP-1:0] want_busy;
        do_reset();
        for (int i = 0; i < NP; i++) rand_port(i);
        for (int c = 0; c < 8; c++) begin
            #1;
            model_eval();
            want_busy = 4'b1111 ^ (4'b0001 << (c % NP));
            n_checks++;
            if (port_busy !== want_busy) begin
                n_errors++; $display("FAIL contention_busy c=%0d got=%b exp=%b", c, port_busy, want_busy);
            end
            tick();
            n_checks++;
            if (grant_id !== GW'(c % NP) || noc_msg_out === NOREQ) begin
                n_errors++; $display("FAIL contention_grant c=%0d got grant=%0d msg=%h exp grant=%0d non-NO_REQ",
                                     c, grant_id, noc_msg_out, c % NP);
            end
            n_checks++;
            if (noc_msg_out !== m_msg || noc_address_out !== m_addr || noc_data_out !== m_data
                || noc_dest_id !== m_dest) begin
                n_errors++; $display("FAIL contention_fields c=%0d got msg=%h addr=%h dest=%0d exp msg=%h addr=%h dest=%0d",
                                     c, noc_msg_out, noc_address_out, noc_dest_id, m_msg, m_addr, m_dest);
            end
            rand_port(c % NP);
        end
    endtask

    task automatic test_stall();
        logic [MB-1:0] s_msg;
        logic [AB-1:0] s_addr;
        logic [LW-1:0] s_data;
        logic [IB-1:0] s_dest;
        s_msg = m_msg; s_addr = m_addr; s_data = m_data; s_dest = m_dest;
        packetizer_busy = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            model_eval();
            n_checks++;
            if (port_busy !== 4'b1111) begin
                n_errors++; $display("FAIL stall_busy c=%0d got=%b exp=1111", c, port_busy);
            end
            tick();
            n_checks++;
            if (noc_msg_out !== s_msg || noc_address_out !== s_addr || noc_data_out !== s_data
                || noc_dest_id !== s_dest || grant_id !== 2'd3) begin
                n_errors++; $display("FAIL stall_hold c=%0d got msg=%h addr=%h grant=%0d exp msg=%h addr=%h grant=3",
                                     c, noc_msg_out, noc_address_out, grant_id, s_msg, s_addr);
            end
        end
        packetizer_busy = 1'b0;
        #1;
        model_eval();
        n_checks++;
        if (port_busy !== 4'b1110) begin
            n_errors++; $display("FAIL stall_release_busy got=%b exp=1110", port_busy);
        end
        tick();
        n_checks++;
        if (grant_id !== 2'd0 || noc_msg_out !== msg_in[0] || noc_address_out !== addr_in[0]) begin
            n_errors++; $display("FAIL stall_release got grant=%0d msg=%h addr=%h exp grant=0 msg=%h addr=%h",
                                 grant_id, noc_msg_out, noc_address_out, msg_in[0], addr_in[0]);
        end
    endtask

    task automatic test_withdraw();
        do_reset();
        set_port(1, MSG_RFO, 32'h2000, 2'd1);
        #1;
        model_eval();
        tick();
        n_checks++;
        if (grant_id !== 2'd1 || noc_msg_out !== MSG_RFO) begin
            n_errors++; $display("FAIL withdraw_first got grant=%0d msg=%h exp grant=1 msg=%h", grant_id, noc_msg_out, MSG_RFO);
        end
        msg_in[1] = NOREQ;
        set_port(0, MSG_READ, 32'h3000, 2'd3);
        packetizer_busy = 1'b1;
        #1;
        model_eval();
        n_checks++;
        if (port_busy !== 4'b1111) begin
            n_errors++; $display("FAIL withdraw_blocked got=%b exp=1111", port_busy);
        end
        tick();
        msg_in[0] = NOREQ;
        packetizer_busy = 1'b0;
        #1;
        model_eval();
        n_checks++;
        if (port_busy !== 4'b1111) begin
            n_errors++; $display("FAIL withdraw_busy got=%b exp=1111", port_busy);
        end
        tick();
        n_checks++;
        if (noc_msg_out !== NOREQ || grant_id !== 2'd1) begin
            n_errors++; $display("FAIL withdraw_idle got msg=%h grant=%0d exp msg=%h grant=1", noc_msg_out, grant_id, NOREQ);
        end
        #1;
        model_eval();
        tick();
        n_checks++;
        if (noc_msg_out !== NOREQ || grant_id !== 2'd1) begin
            n_errors++; $display("FAIL withdraw_stay got msg=%h grant=%0d exp msg=%h grant=1", noc_msg_out, grant_id, NOREQ);
        end
    endtask

    task automatic test_reset_mid_send();
        packetizer_busy = 1'b0;
        set_port(2, MSG_WB, 32'h4000, 2'd2);
        #1;
        model_eval();
        tick();
        n_checks++;
        if (grant_id !== 2'd2 || noc_msg_out !== MSG_WB) begin
            n_errors++; $display("FAIL rst_send_setup got grant=%0d msg=%h exp grant=2 msg=%h", grant_id, noc_msg_out, MSG_WB);
        end
        msg_in[2] = NOREQ;
        packetizer_busy = 1'b1;
        reset = 1'b1;
        #1;
        model_eval();
        tick();
        reset = 1'b0;
        n_checks++;
        if (noc_msg_out !== NOREQ || grant_id !== 2'd0 || noc_address_out !== '0 || noc_dest_id !== '0
            || noc_data_out !== '0) begin
            n_errors++; $display("FAIL rst_send_clear got msg=%h grant=%0d addr=%h dest=%0d exp all zero/NO_REQ",
                                 noc_msg_out, grant_id, noc_address_out, noc_dest_id);
        end
        set_port(1, MSG_READ, 32'h5000, 2'd0);
        set_port(3, MSG_RFO, 32'h6000, 2'd1);
        #1;
        model_eval();
        n_checks++;
        if (port_busy !== 4'b1101) begin
            n_errors++; $display("FAIL rst_send_busy got=%b exp=1101", port_busy);
        end
        tick();
        n_checks++;
        if (grant_id !== 2'd1 || noc_address_out !== 32'h5000) begin
            n_errors++; $display("FAIL rst_send_first got grant=%0d addr=%h exp grant=1 addr=00005000", grant_id, noc_address_out);
        end
    endtask

    task automatic test_random();
        logic [NP-1:0] prev_busy;
        do_reset();
        prev_busy = '1;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NP; i++) begin
                if (msg_in[i] == NOREQ) begin
                    if ($urandom_range(0, 9) < 4) rand_port(i);
                end else if (!prev_busy[i]) begin
                    if ($urandom_range(0, 1) == 0) rand_port(i);
                    else msg_in[i] = NOREQ;
                end else if ($urandom_range(0, 19) == 0) begin
                    msg_in[i] = NOREQ;
                end
            end
            packetizer_busy = ($urandom_range(0, 9) < 3);
            #1;
            model_eval();
            n_checks++;
            if (port_busy !== exp_busy) begin
                n_errors++; $display("FAIL rand_busy c=%0d got=%b exp=%b", c, port_busy, exp_busy);
            end
            prev_busy = exp_busy;
            tick();
            n_checks++;
            if (noc_msg_out !== m_msg || noc_dest_id !== m_dest || grant_id !== GW'(m_grant)
                || (m_msg != NOREQ && (noc_address_out !== m_addr || noc_data_out !== m_data))) begin
                n_errors++;
                $display("FAIL rand_out c=%0d got msg=%h addr=%h dest=%0d grant=%0d exp msg=%h addr=%h dest=%0d grant=%0d",
                         c, noc_msg_out, noc_address_out, noc_dest_id, grant_id, m_msg, m_addr, m_dest, m_grant);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before the bench completed");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        packetizer_busy = 1'b0;
        clear_inputs();
        m_ptr = 0; m_send = 1'b0; m_msg = NOREQ; m_addr = '0; m_data = '0; m_dest = '0; m_grant = 0;
        test_reset();
        test_single_req();
        test_contention();
        test_stall();
        test_withdraw();
        test_reset_mid_send();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
